wb_sram_slave: RTL and testbench
================================

Name: wb_sram_slave

Overview:
Wishbone B4 classic slave that terminates the memory side of the pipeline's Wishbone master unit, backing it with an on-chip word-addressed SRAM array with byte selects.
- Adds a programmable number of wait states.
- Decodes its address window.
- Answers illegal accesses with ERR instead of ACK, so the master's error path is exercised.

Parameters:
- MEM_WORDS, 1024: depth of the array in 32-bit words; power of two, at least 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; aligned to MEM_WORDS*4.
- WAIT_STATES, 1: extra cycles inserted before ACK/ERR; range 0..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- wbs_cyc_i  in  1  bus cycle valid.
- wbs_stb_i  in  1  strobe; a transfer is requested only when it and cyc are both high.
- wbs_we_i  in  1  1 = write, 0 = read.
- wbs_addr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_sel_i  in  4  byte enables; bit n covers bits [8n+7:8n].
- wbs_ack_o  out  1  normal termination, registered.
- wbs_err_o  out  1  error termination, registered.
- wbs_dat_o  out  32  read data, registered.

Behaviour:
Reset state:
- While rst_i is low: ack_o=0, err_o=0, dat_o=0, FSM in IDLE, wait counter=0.
- Array contents are not reset.
- Reset asserted mid-transfer aborts it with no write committed.

FSM has three states: IDLE, WAIT, RESP.

IDLE:
- When cyc&stb are high at an edge, latch addr, dat, sel and we, and classify the request.
- If WAIT_STATES=0, go to RESP; otherwise load the counter with WAIT_STATES-1 and go to WAIT.

WAIT:
- Decrement the counter each edge; when it is 0, go to RESP.
- If cyc_i is sampled low, go to IDLE immediately with no response and no write (abort).

RESP:
- ack_o or err_o is high for exactly one cycle, then return to IDLE.
- A request still presented in the RESP cycle is NOT accepted. The master must drop stb or present a new request, which is sampled in IDLE on the following edge.

Latency:
- Request sampled at edge E0 → ack/err high during the cycle after edge E0+WAIT_STATES+1.
- WAIT_STATES=0 → response in the 2nd cycle after the request is first seen.

Error classification (any one → ERR instead of ACK):
- addr outside [BASE_ADDR, BASE_ADDR+4*MEM_WORDS).
- addr[1:0] != 0.
- sel == 4'b0000.
- An errored access never modifies the array, and dat_o is held unchanged.

Writes:
- Committed on the edge that enters RESP, so an aborted write has no effect.
- Only selected bytes are updated.
- dat_o is held unchanged on writes.

Reads:
- dat_o is loaded on the edge entering RESP with the full word.
- Unselected byte lanes read as 0.
- dat_o holds its value until the next successful read.

Mutual exclusion and cyc:
- ack_o and err_o are never high together.
- Neither is asserted unless cyc_i is high in the RESP cycle. If cyc_i drops on the RESP-entry edge, suppress the response, but a write already committed stands.

Word index: (addr - BASE_ADDR) >> 2, truncated to log2(MEM_WORDS) bits after the range check.

Decomposition:
- Shared package wb_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - WB_DW=32, WB_AW=32, WB_SELW=4
  - function for byte-lane mask expansion from sel
- Natural sub-module: wb_sram_array, a synchronous single-port RAM with per-byte write enable and registered read. It has no reset and is instantiated once.
- FSM, decode and wait counter stay in wb_sram_slave.

Test Plan:
1. Reset: hold rst_i low 3 cycles with cyc/stb high → ack=0, err=0, dat_o=0; release → no spurious ack.
2. WAIT_STATES=1: write 0xDEADBEEF to 0x10 with sel=4'hF, then write 0x00112233 to 0x10 with sel=4'b0101. Read 0x10 with sel=4'hF → dat_o=0xDE11BE33. Each ack comes exactly 3 cycles after stb rises and lasts 1 cycle.
3. WAIT_STATES=3: read any word → ack high 5 cycles after the request edge; count cycles in which ack is low while stb is high = 4.
4. Errors: read 0x4000 (MEM_WORDS=1024, BASE=0), read 0x12, and write 0x20 with sel=0 → err pulses once each, ack never high. A subsequent read of 0x20 returns the prior contents unchanged.
5. Abort: with WAIT_STATES=3, start a write of 0xCAFEF00D to 0x30, then drop cyc after 1 cycle → no ack/err. Reading 0x30 returns the old value.
6. Back-to-back: hold stb high across ack and change the address → the second request is accepted on the IDLE edge after RESP. Two distinct acks, with read data matching each address.

Source files
------------

// File: rtl/wb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_pkg : shared Wishbone widths, slave FSM states, byte-lane helper  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package wb_pkg;

  localparam int unsigned WB_DW   = 32;
  localparam int unsigned WB_AW   = 32;
  localparam int unsigned WB_SELW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  function automatic logic [WB_DW-1:0] sel_to_mask(input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] mask;
    mask = '0;
    for (int i = 0; i < int'(WB_SELW); i++) begin
      mask[8*i +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_sram_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_sram_array : single-port RAM, per-byte write enable, reg'd read   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_sram_array
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [WB_SELW-1:0] be_i,
  input  logic [AW-1:0]      addr_i,
  input  logic [WB_DW-1:0]   wdata_i,
  output logic [WB_DW-1:0]   rdata_o
);

  logic [WB_DW-1:0] mem_q [DEPTH];
  logic [WB_DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < int'(WB_SELW); i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/wb_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wb_sram_slave : Wishbone B4 classic SRAM slave, wait states, ERR     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int unsigned      MEM_WORDS   = 1024,
  parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned      WAIT_STATES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [WB_AW-1:0]   wbs_addr_i,
  input  logic [WB_DW-1:0]   wbs_dat_i,
  input  logic [WB_SELW-1:0] wbs_sel_i,
  output logic               wbs_ack_o,
  output logic               wbs_err_o,
  output logic [WB_DW-1:0]   wbs_dat_o
);

  localparam int unsigned c_idx_w     = $clog2(MEM_WORDS);
  localparam logic [3:0]  c_wait_load = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  wb_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [c_idx_w-1:0]   idx_q, idx_d;
  logic [WB_DW-1:0]     dat_q, dat_d;
  logic [WB_SELW-1:0]   sel_q, sel_d;
  logic                 we_q, we_d;
  logic                 bad_q, bad_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [WB_DW-1:0]     rdat_q, rdat_d;

  logic                 w_req;
  logic [WB_AW-1:0]     w_off;
  logic                 w_bad_in;
  logic [c_idx_w-1:0]   w_idx_in;
  logic                 w_in_idle;
  logic                 w_enter_resp;
  logic                 w_ram_we;
  logic [c_idx_w-1:0]   w_ram_addr;
  logic [WB_DW-1:0]     w_ram_wdata;
  logic [WB_SELW-1:0]   w_ram_be;
  logic [WB_DW-1:0]     w_ram_rdata;

  assign w_req     = wbs_cyc_i & wbs_stb_i;
  assign w_off     = wbs_addr_i - BASE_ADDR;
  assign w_bad_in  = ((w_off >> (c_idx_w + 2)) != '0) || (wbs_addr_i[1:0] != 2'b00) ||
                     (wbs_sel_i == '0);
  assign w_idx_in  = w_off[c_idx_w+1:2];
  assign w_in_idle = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    we_d         = we_q;
    bad_d        = bad_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdat_d       = rdat_q;
    w_enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_req) begin
          idx_d = w_idx_in;
          dat_d = wbs_dat_i;
          sel_d = wbs_sel_i;
          we_d  = wbs_we_i;
          bad_d = w_bad_in;
          if (WAIT_STATES == 0) begin
            state_d      = RESP;
            w_enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = c_wait_load;
          end
        end
      end
      WAIT: begin
        if (!wbs_cyc_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d      = RESP;
          w_enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        // The memory side already happened on entry; a dropped cyc only hides the response.
        if (wbs_cyc_i) begin
          if (bad_q) begin
            err_d = 1'b1;
          end else begin
            ack_d = 1'b1;
            if (!we_q) begin
              rdat_d = w_ram_rdata & sel_to_mask(sel_q);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-wait requests go to the RAM straight from the bus; otherwise from the latches.
  assign w_ram_addr  = w_in_idle ? w_idx_in  : idx_q;
  assign w_ram_wdata = w_in_idle ? wbs_dat_i : dat_q;
  assign w_ram_be    = w_in_idle ? wbs_sel_i : sel_q;
  assign w_ram_we    = w_enter_resp & rst_i &
                       (w_in_idle ? (wbs_we_i & ~w_bad_in) : (we_q & ~bad_q));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      bad_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      bad_q   <= bad_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  wb_sram_array #(
    .DEPTH (MEM_WORDS),
    .AW    (c_idx_w)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (w_ram_we),
    .be_i    (w_ram_be),
    .addr_i  (w_ram_addr),
    .wdata_i (w_ram_wdata),
    .rdata_o (w_ram_rdata)
  );

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = rdat_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_sram_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wb_sram_slave : three slave configurations against a word model   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_wb_sram_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cyc, stb, we, ack, err;
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [31:0] rdat [3];
  logic [3:0]  sel  [3];

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mdl [3][16];
  logic [31:0] exp_rdat [3];
  int          last_low;

  always #5 clk = ~clk;

  wb_sram_slave #(.MEM_WORDS(256), .BASE_ADDR(32'h0001_0000), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .wbs_cyc_i(cyc[0]), .wbs_stb_i(stb[0]), .wbs_we_i(we[0]),
    .wbs_addr_i(addr[0]), .wbs_dat_i(wdat[0]), .wbs_sel_i(sel[0]),
    .wbs_ack_o(ack[0]), .wbs_err_o(err[0]), .wbs_dat_o(rdat[0]));

  wb_sram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .wbs_cyc_i(cyc[1]), .wbs_stb_i(stb[1]), .wbs_we_i(we[1]),
    .wbs_addr_i(addr[1]), .wbs_dat_i(wdat[1]), .wbs_sel_i(sel[1]),
    .wbs_ack_o(ack[1]), .wbs_err_o(err[1]), .wbs_dat_o(rdat[1]));

  wb_sram_slave #(.MEM_WORDS(1024), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3)) u_dut2 (
    .clk_i(clk), .rst_i(rst_n), .wbs_cyc_i(cyc[2]), .wbs_stb_i(stb[2]), .wbs_we_i(we[2]),
    .wbs_addr_i(addr[2]), .wbs_dat_i(wdat[2]), .wbs_sel_i(sel[2]),
    .wbs_ack_o(ack[2]), .wbs_err_o(err[2]), .wbs_dat_o(rdat[2]));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0001_0000 : 32'h0000_0000;
  endfunction

  function automatic int words_of(input int d);
    return (d == 0) ? 256 : 1024;
  endfunction

  function automatic bit is_bad(input int d, input logic [31:0] a, input logic [3:0] s);
    longint unsigned lo, hi, av;
    lo = longint'(base_of(d));
    hi = lo + 4 * words_of(d);
    av = longint'(a);
    return (av < lo) || (av >= hi) || (a % 4 != 0) || (s == 4'b0000);
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) if (s[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic run_txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] s, input bit keep,
                         output logic [1:0] resp, output int lat, output int lowc);
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; wdat[d] = wd; sel[d] = s;
    resp = 2'b00; lat = 0; lowc = 0;
    for (int n = 1; n <= 40 && lat == 0; n++) begin
      @(posedge clk); #1;
      if (ack[d] || err[d]) begin
        resp = {ack[d], err[d]};
        lat  = n;
      end else begin
        lowc++;
      end
    end
    if (!keep) begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
    end
  endtask

  task automatic txn(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] s, input bit keep, input string tag);
    logic [1:0] resp, exp_resp;
    int         lat, lowc, widx;
    bit         bad;
    bad      = is_bad(d, a, s);
    exp_resp = bad ? 2'b01 : 2'b10;
    if (!bad) begin
      widx = int'((a - base_of(d)) / 4);
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) mdl[d][widx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rdat[d] = mdl[d][widx] & lane_mask(s);
      end
    end
    run_txn(d, w, a, wd, s, keep, resp, lat, lowc);
    last_low = lowc;
    chk({tag, "_resp"}, 32'(resp), 32'(exp_resp));
    chk({tag, "_lat"}, lat, ws_of(d) + 2);
    chk({tag, "_rdat"}, rdat[d], exp_rdat[d]);
    if (!keep) begin
      @(posedge clk); #1;
      chk({tag, "_pulse"}, 32'({ack[d], err[d]}), 32'd0);
    end
  endtask

  initial begin
    logic        seen;
    logic [31:0] a, wd;
    logic [3:0]  s;
    logic        w;
    int          r;

    // Reset held with a request on the bus
    rst_n = 1'b0;
    cyc = '1; stb = '1; we = '0;
    for (int d = 0; d < 3; d++) begin
      addr[d] = 32'h10; wdat[d] = '0; sel[d] = 4'hF; exp_rdat[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'd0);
      chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
      chk($sformatf("rst_dat%0d", d), rdat[d], 32'd0);
    end
    @(negedge clk);
    cyc = '0; stb = '0;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | (|ack) | (|err);
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);

    // Fill the first 16 words of every configuration
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        txn(d, 1'b1, base_of(d) + 32'(4 * i), $urandom, 4'hF, 1'b0, $sformatf("init%0d_%0d", d, i));
      end
    end

    // Byte-select merge with one wait state
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, "tp2_wr_full");
    txn(1, 1'b1, 32'h10, 32'h00112233, 4'b0101, 1'b0, "tp2_wr_part");
    txn(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, "tp2_rd");
    chk("tp2_value", rdat[1], 32'hDE11BE33);
    chk("tp2_low_cycles", last_low, 2);

    // Three wait states
    txn(2, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, "tp3_rd");
    chk("tp3_low_cycles", last_low, 4);

    // Error terminations leave data and array alone
    txn(1, 1'b0, 32'h4000, 32'h0, 4'hF, 1'b0, "tp4_oor");
    txn(1, 1'b0, 32'h12, 32'h0, 4'hF, 1'b0, "tp4_misal");
    txn(1, 1'b1, 32'h20, 32'h55AA55AA, 4'h0, 1'b0, "tp4_nosel");
    txn(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, "tp4_rd");

    // Abort during wait states
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h30; wdat[2] = 32'hCAFEF00D; sel[2] = 4'hF;
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | ack[2] | err[2];
    end
    chk("tp5_no_resp", 32'(seen), 32'd0);
    txn(2, 1'b0, 32'h30, 32'h0, 4'hF, 1'b0, "tp5_rd");

    // Back-to-back with strobe held through the acknowledge
    txn(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, "tp6_a");
    txn(1, 1'b0, 32'h20, 32'h0, 4'hF, 1'b0, "tp6_b");

    // Randomized traffic including every error class
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 25; i++) begin
        r  = int'($urandom_range(0, 9));
        w  = 1'($urandom_range(0, 1));
        s  = 4'($urandom_range(1, 15));
        wd = $urandom;
        a  = base_of(d) + 32'(4 * $urandom_range(0, 15));
        if (r == 7) a = a + 32'($urandom_range(1, 3));
        if (r == 8) s = 4'h0;
        if (r == 9) a = ($urandom_range(0, 1) == 0) ? base_of(d) - 32'd4
                                                     : base_of(d) + 32'(4 * words_of(d));
        txn(d, w, a, wd, s, 1'b0, $sformatf("rnd%0d_%0d", d, i));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
